// File: rtl/pipe_drawer.sv
// pipe_drawer: erase/redraw of the pipe rectangle, one pixel per clock.
// Feeds the VGA adapter plot port from the pipe register position.
module pipe_drawer #(
  parameter int         PIPE_W      = 4,
  parameter int         GAP_H       = 20,
  parameter int         SCREEN_W    = 160,
  parameter int         SCREEN_H    = 120,
  parameter logic [2:0] PIPE_COLOUR = 3'b010,
  parameter logic [2:0] BG_COLOUR   = 3'b000
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       game_tick,
  input  logic [8:0] pipe_x,
  input  logic [6:0] pipe_y,
  output logic       busy,
  output logic       plot,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] colour,
  output logic       done
);

  localparam int CW = (PIPE_W > 1) ? $clog2(PIPE_W) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(PIPE_W - 1);
  localparam logic [6:0] R_LAST = 7'(SCREEN_H - 1);
  localparam logic [8:0] X_LIM = 9'(SCREEN_W);
  localparam logic [7:0] GAP_LEN = 8'(GAP_H);

  typedef enum logic [1:0] {
    IDLE,
    ERASE,
    DRAW,
    FINISH
  } state_t;

  state_t state, state_nx;

  logic          accept;
  logic          scan;
  logic          last_pix;
  logic [CW-1:0] c;
  logic [6:0]    r;
  logic [8:0]    new_x, old_x;
  logic [6:0]    new_y;
  logic          valid, pending;
  logic [8:0]    base_x, px;
  logic [7:0]    row8, gap_lo, gap_hi;
  logic          in_gap, pix_on;
  logic          s1_plot, s1_done;
  logic [7:0]    s1_x;
  logic [6:0]    s1_y;
  logic [2:0]    s1_col;

  assign scan     = (state == ERASE) || (state == DRAW);
  assign last_pix = (c == C_LAST) && (r == R_LAST);

  // State register.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nx;
  end

  // Next state and tick acceptance.
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    unique case (state)
      IDLE: begin
        if (game_tick || pending) begin
          accept   = 1'b1;
          state_nx = valid ? ERASE : DRAW;
        end
      end
      ERASE:   if (last_pix) state_nx = DRAW;
      DRAW:    if (last_pix) state_nx = FINISH;
      FINISH:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Row-major scan counters; held at zero outside ERASE/DRAW.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r <= '0;
      c <= '0;
    end else if (!scan) begin
      r <= '0;
      c <= '0;
    end else if (c == C_LAST) begin
      c <= '0;
      r <= (r == R_LAST) ? '0 : r + 7'd1;
    end else begin
      c <= c + CW'(1);
    end
  end

  // Position latches, old-position valid and collapsed pending tick.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      new_x   <= '0;
      new_y   <= '0;
      old_x   <= '0;
      valid   <= 1'b0;
      pending <= 1'b0;
    end else begin
      if (accept) begin
        new_x <= pipe_x;
        new_y <= pipe_y;
      end
      if (state == FINISH) begin
        old_x <= new_x;
        valid <= 1'b1;
      end
      if (game_tick && (state != IDLE)) pending <= 1'b1;
      else if (accept)                  pending <= 1'b0;
    end
  end

  assign base_x = (state == ERASE) ? old_x : new_x;
  assign px     = base_x + 9'(c);
  assign row8   = {1'b0, r};
  assign gap_lo = {1'b0, new_y};
  assign gap_hi = gap_lo + GAP_LEN;
  assign in_gap = (row8 >= gap_lo) && (row8 < gap_hi);
  assign pix_on = scan && (px < X_LIM) &&
                  !((state == DRAW) && in_gap);

  // Pixel select stage.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      s1_plot <= 1'b0;
      s1_done <= 1'b0;
      s1_x    <= '0;
      s1_y    <= '0;
      s1_col  <= BG_COLOUR;
    end else begin
      s1_plot <= pix_on;
      s1_done <= (state == FINISH);
      s1_x    <= px[7:0];
      s1_y    <= r;
      s1_col  <= (state == DRAW) ? PIPE_COLOUR : BG_COLOUR;
    end
  end

  // Registered outputs; busy covers the done cycle.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      plot   <= 1'b0;
      done   <= 1'b0;
      busy   <= 1'b0;
      vga_x  <= '0;
      vga_y  <= '0;
      colour <= BG_COLOUR;
    end else begin
      plot   <= s1_plot;
      done   <= s1_done;
      busy   <= (state != IDLE) || s1_done;
      vga_x  <= s1_x;
      vga_y  <= s1_y;
      colour <= s1_col;
    end
  end

endmodule

// File: tb/tb_pipe_drawer.sv
// tb_pipe_drawer: random passes against a rectangle-level model.
// Checks every plot (x, y, colour, cycle), done timing and busy span.
module tb_pipe_drawer;

  localparam int PW = 4;
  localparam int GH = 20;
  localparam int SW = 160;
  localparam int SH = 120;
  localparam int PIPE = 2;
  localparam int BG = 0;

  logic       CLOCK_50 = 1'b0;
  logic       resetn;
  logic       game_tick;
  logic [8:0] pipe_x;
  logic [6:0] pipe_y;
  logic       busy, plot, done;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] colour;

  pipe_drawer dut (
    .CLOCK_50 (CLOCK_50),
    .resetn   (resetn),
    .game_tick(game_tick),
    .pipe_x   (pipe_x),
    .pipe_y   (pipe_y),
    .busy     (busy),
    .plot     (plot),
    .vga_x    (vga_x),
    .vga_y    (vga_y),
    .colour   (colour),
    .done     (done)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    int x;
    int y;
    int col;
    int t;
  } pix_t;

  pix_t exp_q[$];
  pix_t got_q[$];
  int   done_q[$];
  int   ncyc = 0;
  int   busy_cnt = 0;
  int   total = 0;
  int   passed = 0;
  int   m_old = 0;
  bit   m_valid = 0;
  int   t0 = 0;

  always @(negedge CLOCK_50) begin
    ncyc++;
    if (plot === 1'b1)
      got_q.push_back('{int'(vga_x), int'(vga_y), int'(colour), ncyc});
    if (busy === 1'b1) busy_cnt++;
    if (done === 1'b1) done_q.push_back(ncyc);
  end

  task automatic clear_obs();
    exp_q.delete();
    got_q.delete();
    done_q.delete();
    busy_cnt = 0;
  endtask

  task automatic drive_tick(input int x, input int y);
    @(negedge CLOCK_50);
    #1;
    pipe_x = 9'(x);
    pipe_y = 7'(y);
    game_tick = 1'b1;
    t0 = ncyc + 1;
    @(negedge CLOCK_50);
    #1;
    game_tick = 1'b0;
  endtask

  task automatic wait_done(input int n, output bit ok);
    int k = 0;
    while (done_q.size() < n && k < 5000) begin
      @(negedge CLOCK_50);
      k++;
    end
    ok = (done_q.size() >= n);
    repeat (3) @(negedge CLOCK_50);
    #1;
  endtask

  // Rectangle model: erase the whole old column band, then paint
  // the new band minus the gap; pixels come out one per cycle.
  task automatic model_pass(input int nx, input int ny,
                            input int base, output int len);
    int off = 2;
    if (m_valid) begin
      for (int y = 0; y < SH; y++)
        for (int k = 0; k < PW; k++) begin
          if (m_old + k < SW)
            exp_q.push_back('{m_old + k, y, BG, base + off});
          off++;
        end
    end
    for (int y = 0; y < SH; y++)
      for (int k = 0; k < PW; k++) begin
        if (nx + k < SW && !(y >= ny && y < ny + GH))
          exp_q.push_back('{nx + k, y, PIPE, base + off});
        off++;
      end
    len = off;
    m_old = nx;
    m_valid = 1;
  endtask

  function automatic int diff_plots(output int first);
    int n, m;
    first = -1;
    n = (exp_q.size() > got_q.size()) ?
        exp_q.size() - got_q.size() : got_q.size() - exp_q.size();
    m = (exp_q.size() < got_q.size()) ? exp_q.size() : got_q.size();
    for (int i = 0; i < m; i++)
      if (exp_q[i].x != got_q[i].x || exp_q[i].y != got_q[i].y ||
          exp_q[i].col != got_q[i].col || exp_q[i].t != got_q[i].t) begin
        n++;
        if (first < 0) first = i;
      end
    return n;
  endfunction

  function automatic int count_col(input int col);
    int n = 0;
    foreach (got_q[i]) if (got_q[i].col == col) n++;
    return n;
  endfunction

  task automatic check_single(input string nm, input int len, input bit ok);
    int nd, fi;
    nd = diff_plots(fi);
    total++;
    if (nd != 0) begin
      $display("FAIL %s plots: %0d differences, got %0d plots, expected %0d, first bad index %0d",
               nm, nd, got_q.size(), exp_q.size(), fi);
      if (fi >= 0)
        $display("  got x=%0d y=%0d c=%0d t=%0d, expected x=%0d y=%0d c=%0d t=%0d",
                 got_q[fi].x, got_q[fi].y, got_q[fi].col, got_q[fi].t,
                 exp_q[fi].x, exp_q[fi].y, exp_q[fi].col, exp_q[fi].t);
    end else passed++;
    total++;
    if (!ok || done_q.size() != 1 || done_q[0] != t0 + len) begin
      $display("FAIL %s done: got %0d pulses first at %0d, expected 1 at %0d",
               nm, done_q.size(), (done_q.size() > 0) ? done_q[0] : -1, t0 + len);
    end else passed++;
    total++;
    if (busy_cnt !== len) begin
      $display("FAIL %s busy: got %0d cycles, expected %0d", nm, busy_cnt, len);
    end else passed++;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    game_tick = 1'b0;
    pipe_x = '0;
    pipe_y = '0;
    repeat (3) @(negedge CLOCK_50);
    total++;
    if ({busy, plot, done} !== 3'b000) begin
      $display("FAIL reset_ctrl: got %b, expected 000", {busy, plot, done});
    end else passed++;
    total++;
    if ({vga_x, vga_y, colour} !== {8'd0, 7'd0, 3'(BG)}) begin
      $display("FAIL reset_data: got x=%0d y=%0d c=%0d, expected 0 0 %0d",
               vga_x, vga_y, colour, BG);
    end else passed++;
    #1;
    resetn = 1'b1;
    m_valid = 0;
    clear_obs();
    repeat (5) @(negedge CLOCK_50);
    total++;
    if (got_q.size() != 0 || busy_cnt != 0) begin
      $display("FAIL idle_after_reset: got %0d plots %0d busy, expected 0 0",
               got_q.size(), busy_cnt);
    end else passed++;
  endtask

  task automatic test_first_pass();
    int len;
    bit ok;
    clear_obs();
    drive_tick(50, 30);
    model_pass(50, 30, t0, len);
    wait_done(1, ok);
    check_single("first_pass", len, ok);
    total++;
    if (got_q.size() != 400 || busy_cnt != 482) begin
      $display("FAIL first_pass_count: got %0d plots %0d busy, expected 400 482",
               got_q.size(), busy_cnt);
    end else passed++;
  endtask

  task automatic test_move();
    int len;
    bit ok;
    clear_obs();
    drive_tick(49, 30);
    model_pass(49, 30, t0, len);
    wait_done(1, ok);
    check_single("move", len, ok);
    total++;
    if (count_col(BG) != 480 || count_col(PIPE) != 400) begin
      $display("FAIL move_count: got %0d erase %0d draw, expected 480 400",
               count_col(BG), count_col(PIPE));
    end else passed++;
  endtask

  task automatic test_right_edge();
    int len;
    bit ok;
    clear_obs();
    drive_tick(158, 30);
    model_pass(158, 30, t0, len);
    wait_done(1, ok);
    check_single("edge158", len, ok);
    total++;
    if (count_col(PIPE) != 200) begin
      $display("FAIL edge158_draw: got %0d, expected 200", count_col(PIPE));
    end else passed++;
    clear_obs();
    drive_tick(160, 30);
    model_pass(160, 30, t0, len);
    wait_done(1, ok);
    check_single("edge160", len, ok);
    total++;
    if (got_q.size() != 240 || busy_cnt != 962) begin
      $display("FAIL edge160_count: got %0d plots %0d busy, expected 240 962",
               got_q.size(), busy_cnt);
    end else passed++;
  endtask

  task automatic test_pending();
    int len1, len2, ta, xd, yd, nd, fi;
    bit ok;
    clear_obs();
    drive_tick($urandom_range(0, 160), $urandom_range(0, 100));
    ta = t0;
    model_pass(int'(pipe_x), int'(pipe_y), ta, len1);
    for (int i = 0; i < 3; i++) begin
      repeat (150) @(negedge CLOCK_50);
      drive_tick($urandom_range(0, 160), $urandom_range(0, 100));
    end
    xd = $urandom_range(0, 160);
    yd = $urandom_range(0, 100);
    pipe_x = 9'(xd);
    pipe_y = 7'(yd);
    model_pass(xd, yd, ta + len1, len2);
    wait_done(2, ok);
    repeat (1100) @(negedge CLOCK_50);
    nd = diff_plots(fi);
    total++;
    if (nd != 0) begin
      $display("FAIL pending plots: %0d differences, got %0d plots, expected %0d, first bad %0d",
               nd, got_q.size(), exp_q.size(), fi);
    end else passed++;
    total++;
    if (!ok || done_q.size() != 2 || done_q[0] != ta + len1 ||
        done_q[1] != ta + len1 + len2) begin
      $display("FAIL pending done: got %0d pulses, expected 2 at %0d and %0d",
               done_q.size(), ta + len1, ta + len1 + len2);
    end else passed++;
    total++;
    if (busy_cnt != len1 + len2) begin
      $display("FAIL pending busy: got %0d, expected %0d", busy_cnt, len1 + len2);
    end else passed++;
  endtask

  task automatic test_reset_mid();
    int len, k;
    bit ok;
    clear_obs();
    drive_tick($urandom_range(0, 156), $urandom_range(0, 100));
    k = 0;
    while (ncyc < t0 + 2 + 480 + 200 && k < 3000) begin
      @(negedge CLOCK_50);
      k++;
    end
    #1;
    resetn = 1'b0;
    #1;
    total++;
    if ({busy, plot, done} !== 3'b000) begin
      $display("FAIL reset_mid_async: got %b, expected 000", {busy, plot, done});
    end else passed++;
    repeat (2) @(negedge CLOCK_50);
    #1;
    resetn = 1'b1;
    m_valid = 0;
    clear_obs();
    repeat (10) @(negedge CLOCK_50);
    total++;
    if (got_q.size() != 0 || busy_cnt != 0 || done_q.size() != 0) begin
      $display("FAIL reset_mid_quiet: got %0d plots %0d busy, expected 0 0",
               got_q.size(), busy_cnt);
    end else passed++;
    clear_obs();
    drive_tick($urandom_range(0, 160), $urandom_range(0, 100));
    model_pass(int'(pipe_x), int'(pipe_y), t0, len);
    wait_done(1, ok);
    check_single("after_reset", len, ok);
    total++;
    if (count_col(BG) != 0 || busy_cnt != 482) begin
      $display("FAIL after_reset_noerase: got %0d erase %0d busy, expected 0 482",
               count_col(BG), busy_cnt);
    end else passed++;
  endtask

  task automatic test_gap_bottom();
    int len, x;
    bit ok;
    clear_obs();
    x = $urandom_range(0, 156);
    drive_tick(x, 100);
    model_pass(x, 100, t0, len);
    wait_done(1, ok);
    check_single("gap_bottom", len, ok);
    total++;
    if (count_col(PIPE) != 400) begin
      $display("FAIL gap_bottom_count: got %0d, expected 400", count_col(PIPE));
    end else passed++;
  endtask

  task automatic test_random();
    int len, x, y;
    bit ok;
    for (int i = 0; i < 6; i++) begin
      clear_obs();
      x = $urandom_range(0, 160);
      y = $urandom_range(0, 127);
      drive_tick(x, y);
      model_pass(x, y, t0, len);
      wait_done(1, ok);
      check_single($sformatf("random%0d", i), len, ok);
    end
  endtask

  initial begin
    test_reset();
    test_first_pass();
    test_move();
    test_right_edge();
    test_pending();
    test_reset_mid();
    test_gap_bottom();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
